// File: rtl/stochastic_decoder.sv
// stochastic_decoder
//   Converts a unipolar stochastic bitstream back into a binary count. It
//   counts the ones seen over a window of N = 2**LOG_LEN valid samples.
//   The result is held until the next conversion completes.
//
//   Optional feature macro: STOCH_DEC_RUNNING_EN
//   When this macro is defined, the running_count output exposes the live
//   partial ones count.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   request a conversion (accepted only in IDLE)
//   abort         in   cancel the conversion in progress; result untouched
//   bitstream_in  in   stochastic sample bit
//   bit_valid     in   bitstream_in carries a sample this cycle
//   busy          out  high while accumulating
//   done          out  one-cycle pulse when result updates
//   result        out  ones counted in the last completed window (0..N)
//   running_count out  live ones count (STOCH_DEC_RUNNING_EN only)
module stochastic_decoder #(
  parameter int LOG_LEN = 8,
  parameter int RES_W   = LOG_LEN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bitstream_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
`ifdef STOCH_DEC_RUNNING_EN
  output logic [RES_W-1:0] running_count,
`endif
  output logic [RES_W-1:0] result
);

  localparam int CW = LOG_LEN + 1;
  // Sample index of the Nth valid sample (N-1 counted before it).
  localparam logic [CW-1:0] LAST = {1'b0, {LOG_LEN{1'b1}}};

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [RES_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      result_q     <= result_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    result_d     = result_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort has priority over start, even in IDLE
        if (start && !abort) begin
          state_d      = ACCUM;
          sample_cnt_d = '0;
          ones_cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (abort) begin
          // The sample at the abort edge is dropped; counters are frozen so
          // the optional running count keeps its partial value.
          state_d = IDLE;
        end else if (bit_valid) begin
          sample_cnt_d = sample_cnt_q + CW'(1);
          ones_cnt_d   = ones_cnt_q + RES_W'(bitstream_in);
          if (sample_cnt_q == LAST) begin
            state_d  = IDLE;
            result_d = ones_cnt_d;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == ACCUM);
  assign done   = done_q;
  assign result = result_q;
`ifdef STOCH_DEC_RUNNING_EN
  assign running_count = ones_cnt_q;
`endif

endmodule

// File: tb/tb_stochastic_decoder.sv
module tb_stochastic_decoder;
  localparam int LOG_LEN = 4;
  localparam int N       = 16;
  localparam int RES_W   = LOG_LEN + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0;
  logic             bitstream_in = 1'b0, bit_valid = 1'b0;
  logic             busy, done;
  logic [RES_W-1:0] result;
`ifdef STOCH_DEC_RUNNING_EN
  logic [RES_W-1:0] running_count;
`endif

  int checks   = 0;
  int failures = 0;
  int sb[$];

  always #5 clk = ~clk;

  stochastic_decoder #(.LOG_LEN(LOG_LEN), .RES_W(RES_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .bitstream_in (bitstream_in),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done),
`ifdef STOCH_DEC_RUNNING_EN
    .running_count(running_count),
`endif
    .result       (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        chk("sb_result", 32'(result), 32'(sb.pop_front()));
      end
    end
  end

  // One clock with the given inputs; outputs are stable 1 time unit later.
  task automatic tick(input logic st, input logic ab, input logic bv, input logic b);
    start = st; abort = ab; bit_valid = bv; bitstream_in = b;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bitstream_in = 1'b0;
  endtask

  task automatic feed(input int n, input logic b);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, b);
  endtask

  initial begin
    // reset
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 1'b0;
    tick(0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
`ifdef STOCH_DEC_RUNNING_EN
    chk("rst_running", 32'(running_count), 0);
`endif

    // start+abort together in IDLE: stays idle
    tick(1, 1, 0, 0);
    chk("idle_abort_wins", 32'(busy), 0);

    // all ones -> N
    tick(1, 0, 0, 1);
    chk("t1_busy", 32'(busy), 1);
    feed(N-1, 1);
    chk("t1_no_early_done", 32'(done), 0);
    chk("t1_busy_before_last", 32'(busy), 1);
    sb.push_back(N);
    feed(1, 1);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_result", 32'(result), N);
    tick(0, 0, 0, 0);
    chk("t1_done_one_cycle", 32'(done), 0);
    chk("t1_result_hold", 32'(result), N);

    // all zeros -> 0
    tick(1, 0, 0, 0);
    sb.push_back(0);
    feed(N, 0);
    chk("t2_done", 32'(done), 1);
    chk("t2_result", 32'(result), 0);
    tick(0, 0, 0, 0);
    chk("t2_done_one_cycle", 32'(done), 0);

    // alternating 1,0 with a gap every third cycle -> N/2
    tick(1, 0, 0, 0);
    begin
      int nv = 0;
      int cyc = 0;
      while (nv < N) begin
        if (cyc % 3 == 2) begin
          tick(0, 0, 0, 1);
        end else begin
          if (nv == N-1) sb.push_back(N/2);
          tick(0, 0, 1, (nv % 2 == 0));
          nv++;
        end
        cyc++;
      end
    end
    chk("t3_done", 32'(done), 1);
    chk("t3_result", 32'(result), N/2);

    // abort mid-conversion: result keeps 8
    tick(1, 0, 0, 0);
    feed(10, 1);
`ifdef STOCH_DEC_RUNNING_EN
    chk("t4_running10", 32'(running_count), 10);
`endif
    tick(0, 1, 1, 1);
    chk("t4_abort_busy", 32'(busy), 0);
    chk("t4_abort_done", 32'(done), 0);
    chk("t4_abort_result", 32'(result), N/2);
`ifdef STOCH_DEC_RUNNING_EN
    chk("t4_running_hold", 32'(running_count), 10);
`endif
    tick(0, 0, 0, 0);
    chk("t4_no_late_done", 32'(done), 0);
    tick(1, 0, 0, 0);
    sb.push_back(N);
    feed(N, 1);
    chk("t4_restart_result", 32'(result), N);

    // abort coincident with the Nth valid sample: abort wins
    tick(1, 0, 0, 0);
    feed(N-1, 0);
    tick(0, 1, 1, 0);
    chk("t5_coinc_done", 32'(done), 0);
    chk("t5_coinc_busy", 32'(busy), 0);
    chk("t5_coinc_result", 32'(result), N);

    // start during ACCUM ignored; completes after 11 more samples
    tick(1, 0, 0, 0);
    feed(5, 1);
    tick(1, 0, 0, 0);
    chk("t6_start_ignored_busy", 32'(busy), 1);
    feed(10, 0);
    chk("t6_no_restart_early", 32'(done), 0);
    sb.push_back(5);
    feed(1, 0);
    chk("t6_done", 32'(done), 1);
    chk("t6_result", 32'(result), 5);
    // start in the done cycle is accepted
    tick(1, 0, 0, 0);
    chk("t6_start_in_done", 32'(busy), 1);
`ifdef STOCH_DEC_RUNNING_EN
    chk("t6_running_clear", 32'(running_count), 0);
`endif
    feed(1, 1);
`ifdef STOCH_DEC_RUNNING_EN
    chk("t6_running1", 32'(running_count), 1);
`endif
    feed(1, 1);
`ifdef STOCH_DEC_RUNNING_EN
    chk("t6_running2", 32'(running_count), 2);
`endif

    // reset mid-ACCUM
    rst = 1'b1;
    tick(0, 0, 1, 1);
    rst = 1'b0;
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_done", 32'(done), 0);
    chk("t7_rst_result", 32'(result), 0);
`ifdef STOCH_DEC_RUNNING_EN
    chk("t7_rst_running", 32'(running_count), 0);
`endif
    tick(0, 0, 1, 1);
    chk("t7_stay_idle", 32'(busy), 0);

    tick(0, 0, 0, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stochastic_decoder.md
Name: stochastic_decoder

Overview:
- Downstream stage for the stochastic arithmetic blocks, such as the scaled adder and multiplier.
- Converts a unipolar stochastic bitstream back to a binary count by counting ones over a fixed window of N = 2^LOG_LEN valid samples.
- Start/done handshake; the result is held until the next completed conversion.
- Sits between the bitstream datapath and the REPL readout logic.

Parameters:
- LOG_LEN, 8: log2 of window length; N = 2^LOG_LEN valid samples per conversion.
- RES_W, LOG_LEN+1: result width; must hold values 0..N inclusive. Do not override below LOG_LEN+1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; accepted only in IDLE.
- abort  input  1  cancel the conversion in progress; result is not updated.
- bitstream_in  input  1  stochastic bit, e.g. an adder result_bitstream.
- bit_valid  input  1  bitstream_in is a sample this cycle.
- busy  output  1  high while in ACCUM.
- done  output  1  one-cycle pulse when result updates.
- result  output  RES_W  number of ones counted in the last completed window.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, busy=0, done=0, result=0, ones_cnt=0, sample_cnt=0.
- Reset has priority over all other inputs and aborts any conversion in progress.
- Registers:
  - state: IDLE or ACCUM.
  - sample_cnt: LOG_LEN+1 bits.
  - ones_cnt: RES_W bits.
  - result: RES_W bits.
  - done: 1 bit.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - start=1 and abort=0 at edge t -> state=ACCUM, busy=1, ones_cnt=0, sample_cnt=0 at t+1.
  - The bitstream_in sample at cycle t is NOT counted.
  - start=1 with abort=1 in IDLE: abort wins; remain IDLE.
- ACCUM:
  - Each edge with bit_valid=1: sample_cnt+=1; ones_cnt+=bitstream_in.
  - bit_valid=0: both counters hold; gaps do not count toward N.
  - start in ACCUM is ignored; no restart.
  - abort=1 at an edge -> IDLE next cycle, busy=0, done stays 0, result unchanged. The sample at the abort edge is discarded.
- Completion:
  - When the Nth valid sample is accepted at edge k: result = ones_cnt including that sample, done=1, busy=0, state=IDLE, all at k+1.
  - Latency: conversion ends exactly one cycle after the Nth valid sample.
  - abort coincident with the Nth valid sample: abort wins; no done, result unchanged.
- done:
  - High for exactly one cycle, then 0.
  - start asserted during the done cycle is accepted (state is IDLE) -> ACCUM next cycle.
  - Back-to-back conversions have a 1-cycle gap.
- Arithmetic:
  - ones_cnt never exceeds N, so no wrap.
  - All-ones input gives result=N, which is the reason for RES_W=LOG_LEN+1.
  - Counters are unsigned.
- result holds its value through IDLE, through subsequent ACCUM, and through abort; it changes only on completion or reset.
- Estimated value = result/N; scaling is downstream's responsibility.

Optional Feature:
- Macro: STOCH_DEC_RUNNING_EN
- Defined:
  - Adds output running_count [RES_W-1:0], equal to the registered ones_cnt: live partial count, updated the cycle after each valid sample.
  - Reads 0 from reset until the first accepted start.
  - Cleared the cycle after start is accepted.
  - Holds its value in IDLE after completion or abort.
- Undefined: the port does not exist; core behaviour is identical.

Test Plan (LOG_LEN=4, N=16):
- Reset, start, then 16 cycles of bit_valid=1, bitstream_in=1 -> done pulse one cycle after the 16th sample, result=16, busy falls with done.
- Start, then 16 valid samples of bitstream_in=0 -> result=0, done=1 for exactly one cycle.
- Start, then valid alternating pattern 1,0,1,0... with bit_valid=0 on every third cycle -> only valid samples counted; result=8 after 16 valid samples (about 24 cycles total).
- Complete a conversion with result=8; start again, feed 10 valid ones, pulse abort -> busy=0 next cycle, no done, result stays 8. Start again with 16 ones -> result=16.
- During ACCUM after 5 valid samples, pulse start -> ignored, conversion completes after 11 more valid samples. Start asserted in the done cycle -> busy=1 next cycle.
- Mid-ACCUM, assert rst for one cycle -> busy=0, done=0, result=0 the next cycle. With STOCH_DEC_RUNNING_EN: running_count increments 0→1→2 on consecutive valid ones, and running_count=0 after rst.
